// File: rtl/pulse_rate_meter_pkg.sv
// rtl/pulse_rate_meter_pkg.sv - shared window defaults and result register state encoding
package pulse_rate_meter_pkg;

    // Matches one full wrap of the upstream 4-bit pulse counter.
    localparam int DEF_WINDOW  = 16;
    localparam int DEF_COUNT_W = 8;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/pulse_rate_meter_window_timer.sv
// rtl/pulse_rate_meter_window_timer.sv - counted-cycle window position and window end strobe
module window_timer
    import pulse_rate_meter_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic window_end
);

    localparam int WCNT_W = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WINDOW - 1);

    logic [WCNT_W-1:0] wcnt;

    assign window_end = en && (wcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (window_end) begin
            wcnt <= '0;
        end else if (en) begin
            wcnt <= wcnt + WCNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_rate_meter.sv
// rtl/pulse_rate_meter.sv - windowed pulse event counter with handshaked result and overrun flag
module pulse_rate_meter
    import pulse_rate_meter_pkg::*;
#(
    parameter int WINDOW  = DEF_WINDOW,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               pulse,
    output logic [COUNT_W-1:0] result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [COUNT_W-1:0] evcnt;
    logic [COUNT_W-1:0] total;
    logic [0:0]         state;
    logic               window_end;
    logic               take;

    window_timer #(.WINDOW(WINDOW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .window_end (window_end)
    );

    // Saturating count including this cycle's pulse; also the value latched at window end.
    assign total = (pulse && (evcnt != CNT_MAX)) ? evcnt + COUNT_W'(1) : evcnt;
    assign take  = (state == ST_FULL) && result_ready;

    assign result_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            evcnt   <= '0;
            result  <= '0;
            state   <= ST_EMPTY;
            overrun <= 1'b0;
        end else if (window_end) begin
            evcnt  <= '0;
            result <= total;
            state  <= ST_FULL;
            if ((state == ST_FULL) && !result_ready) begin
                overrun <= 1'b1;
            end
        end else begin
            if (en) begin
                evcnt <= total;
            end
            if (take) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_pulse_rate_meter.sv
// tb/tb_pulse_rate_meter.sv - directed bench with cycle-level reference model for pulse_rate_meter
module tb_pulse_rate_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pulse;
    logic       result_ready;
    logic [7:0] result_a;
    logic [2:0] result_b;
    logic       valid_a, valid_b, ovr_a, ovr_b;

    always #5 clk = ~clk;

    pulse_rate_meter #(.WINDOW(16), .COUNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse),
        .result(result_a), .result_valid(valid_a),
        .result_ready(result_ready), .overrun(ovr_a)
    );

    pulse_rate_meter #(.WINDOW(16), .COUNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse),
        .result(result_b), .result_valid(valid_b),
        .result_ready(result_ready), .overrun(ovr_b)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: index 0 is the 8-bit instance, index 1 the 3-bit instance.
    int mpos[2];
    int mev[2];
    int mres[2];
    int mval[2];
    int movr[2];

    function automatic int cap(input int k);
        return (k == 0) ? 255 : 7;
    endfunction

    always @(posedge clk) begin
        int n;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mpos[k] = 0; mev[k] = 0; mres[k] = 0; mval[k] = 0; movr[k] = 0;
            end else if (en && mpos[k] == 15) begin
                n = mev[k] + (pulse ? 1 : 0);
                mres[k] = (n > cap(k)) ? cap(k) : n;
                if (mval[k] == 1 && !result_ready) movr[k] = 1;
                mval[k] = 1;
                mev[k]  = 0;
                mpos[k] = 0;
            end else begin
                if (en) begin
                    mpos[k] = mpos[k] + 1;
                    if (pulse && mev[k] < cap(k)) mev[k] = mev[k] + 1;
                end
                if (mval[k] == 1 && result_ready) mval[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_result_a", int'(result_a), mres[0]);
            check("model_valid_a",  int'(valid_a),  mval[0]);
            check("model_overrun_a", int'(ovr_a),   movr[0]);
            check("model_result_b", int'(result_b), mres[1]);
            check("model_valid_b",  int'(valid_b),  mval[1]);
            check("model_overrun_b", int'(ovr_b),   movr[1]);
        end
    end

    task automatic cyc(input logic e, input logic p, input logic r);
        en = e; pulse = p; result_ready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    int nval, sumres, first, q8[$], q3[$];

    initial begin
        rst = 1'b1; en = 1'b0; pulse = 1'b0; result_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("reset_result", int'(result_a), 0);
        check("reset_valid", int'(valid_a), 0);
        check("reset_overrun", int'(ovr_a), 0);
        rst = 1'b0;

        // One upstream pulse per 16 cycles, consumer always ready.
        nval = 0; sumres = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, (i % 16) == 3, 1'b1);
            if (valid_a) begin nval++; sumres += int'(result_a); end
        end
        check("periodic_valid_count", nval, 4);
        check("periodic_result_sum", sumres, 4);
        check("periodic_overrun", int'(ovr_a), 0);

        // 40 pulses then idle, plus saturation in the 3-bit instance.
        do_reset();
        q8.delete(); q3.delete();
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1, i < 40, 1'b1);
            if (valid_a) q8.push_back(int'(result_a));
            if (valid_b) q3.push_back(int'(result_b));
        end
        check("burst_count", q8.size(), 3);
        if (q8.size() == 3) begin
            check("burst_r0", q8[0], 16);
            check("burst_r1", q8[1], 16);
            check("burst_r2", q8[2], 8);
        end
        check("sat_count", q3.size(), 3);
        if (q3.size() == 3) check("sat_r0", q3[0], 7);

        // Two window ends without a read.
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b0);
        check("ovr_result", int'(result_a), 16);
        check("ovr_valid", int'(valid_a), 1);
        check("ovr_flag", int'(ovr_a), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("ovr_read_valid", int'(valid_a), 0);
        check("ovr_sticky", int'(ovr_a), 1);

        // Read coinciding with a window end.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, (i < 2) || (i >= 16 && i < 21), i == 31);
            if (i == 15) check("coinc_first", int'(result_a), 2);
        end
        check("coinc_valid", int'(valid_a), 1);
        check("coinc_result", int'(result_a), 5);
        check("coinc_overrun", int'(ovr_a), 0);

        // Enable gap of 5 cycles delays the window end by 5.
        do_reset();
        first = -1;
        for (int i = 0; i < 21; i++) begin
            cyc(!(i >= 5 && i < 10), 1'b1, i == 20 ? 1'b0 : 1'b1);
            if (valid_a && first < 0) first = i;
        end
        check("gap_first_valid", first, 20);
        check("gap_result", int'(result_a), 16);

        // Reset mid-window with an unread result pending.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
        check("pre_rst_valid", int'(valid_a), 1);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_result", int'(result_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_overrun", int'(ovr_a), 0);
        for (int i = 0; i < 16; i++) cyc(1'b1, i < 3, 1'b0);
        check("post_rst_valid", int'(valid_a), 1);
        check("post_rst_result", int'(result_a), 3);
        check("post_rst_result_b", int'(result_b), 3);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
